ai_decision_engine: RTL
=======================

Name: ai_decision_engine

Overview:
- Downstream consumer of the AI-side game-state encoder.
- On each start pulse it reads one player's encoded view: bullet slot codes, own item counts, HPs and phase flags.
- It scans the magazine serially and selects an action by a fixed priority policy.
- It issues the action to the game controller over a valid/ready handshake. In item phase it loops for several item actions before ending the phase.

Parameters:
- MAX_HP, 4, HP ceiling; cigarette is never used at hp_self == MAX_HP.
- MAX_ITEM_ACTS, 4, max item actions per item phase, including the final END_ITEM.
- N_SLOTS, 8, magazine slots scanned; fixed at 8 by the encoder format.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse: it is this AI's turn
- i_phase_item  in  1  item phase active
- i_phase_shoot  in  1  shoot phase active
- i_slot  in  16  slot k = i_slot[2k+1:2k]; 00 pad, 01 unknown, 10 live, 11 blank
- i_cur_idx  in  3  index of the next slot to fire
- i_live_rem  in  4  live rounds remaining, current slot included
- i_blank_rem  in  4  blank rounds remaining, current slot included
- i_hp_self  in  3  own HP
- i_item_cnt  in  21  own count of item type t = i_item_cnt[3t+2:3t], t = 0..6
- o_act_valid  out  1  action valid
- o_act_code  out  4  action code
- i_act_ready  in  1  controller accepts action
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when a turn sequence completes

Behaviour:
- Reset values: o_act_valid=0, o_act_code=4'hF, o_busy=0, o_done=0, FSM=IDLE, all counters and flags 0.
- Action codes:
  - 0..6: use item type t. 0 magnifier, 1 beer, 2 saw, 3 cigarette, 4 handcuff, 5 phone, 6 inverter.
  - 8: SHOOT_SELF.
  - 9: SHOOT_OPP.
  - 15: END_ITEM.
- FSM states: IDLE, SCAN, DECIDE, ISSUE, SETTLE.
- IDLE:
  - i_start with exactly one phase flag high → SCAN. Clear scan counters, saw_used and act_cnt.
  - i_start with neither or both flags high → ignored.
- SCAN: one slot per cycle, k = 0..7, 8 cycles.
  - For k ≥ i_cur_idx: code 10 increments kn_live, code 11 increments kn_blank.
  - Codes 00 and 01 are not counted.
  - Capture cur_code = slot[i_cur_idx].
- DECIDE (1 cycle):
  - unk_live = sat0(i_live_rem − kn_live).
  - unk_blank = sat0(i_blank_rem − kn_blank).
  - All arithmetic is 4-bit unsigned with saturation at 0.
- Item-phase priority, first match wins:
  1. i_hp_self < MAX_HP and cnt[3] > 0 → 3.
  2. cur_code == 01 and cnt[0] > 0 → 0.
  3. cur_code == 10 and cnt[2] > 0 and !saw_used → 2; set saw_used.
  4. cur_code == 11 and cnt[1] > 0 → 1.
  5. Otherwise → 15.
  - When act_cnt == MAX_ITEM_ACTS−1, the action is forced to 15.
- Shoot-phase decision:
  - cur_code 10 → 9.
  - cur_code 11 → 8.
  - cur_code 01 → 9 if unk_live ≥ unk_blank (tie goes to 9), else 8.
  - cur_code 00 is illegal → 8.
- ISSUE:
  - o_act_valid=1; o_act_code is held stable until the cycle where valid & ready. A 1-cycle ready at ISSUE entry is accepted.
  - On handshake: valid drops the next cycle, act_cnt++.
  - Item action other than 15 → SETTLE.
  - Otherwise → IDLE with o_done=1 for 1 cycle.
- SETTLE: 2 cycles so controller state can update, then → SCAN to rescan with fresh inputs.
- Abort: both phase flags low while in SCAN, DECIDE, ISSUE or SETTLE → IDLE next cycle. Valid drops, no o_done, no act_cnt update.
- i_start while busy → ignored.
- Latency from i_start to first o_act_valid: 10 cycles (1 IDLE → SCAN, 8 SCAN, 1 DECIDE).

Decomposition:
- Package ai_pkg contains:
  - action-code localparams and item-type indices;
  - slot-code constants (PAD, UNK, LIVE, BLANK);
  - FSM state enum.
- One sub-module, ai_slot_counter: serial 8-slot scanner producing kn_live, kn_blank, cur_code and a scan_done pulse.

Test Plan:
- Shoot phase, slots all 01, cur_idx=0, live_rem=3, blank_rem=2, start → code 9 after 10 cycles; o_done pulses after ready.
- Shoot phase, cur_idx=2, slot2=11 → code 8.
- Shoot phase, cur_idx=0, all slots 01 except slots 1..3 = 10, live_rem=3, blank_rem=2 → unk_live=0 < unk_blank=2 → code 8.
- Item phase, hp_self=2, cnt[3]=1, cnt[0]=1, cur_code 01 → code 3.
  - After ack, drive cnt[3]=0 → second action code 0.
  - After ack, drive cur slot to 11 with cnt[1]=0 → 15, o_done.
- Item phase, hp_self=4, cur slot 10, cnt[2]=2 unchanged across acks → codes 2, then 15 (saw_used blocks repeat); act_cnt limit respected.
- Hold i_act_ready low 5 cycles: valid and code remain stable.
- Drop both phase flags mid-ISSUE: valid falls in 1 cycle and no o_done.
- Assert rst_n low mid-SCAN: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ai_pkg.sv
// ai_pkg: shared constants for the AI decision engine.
//   - act_e: action codes presented to the game controller (0..6 double as item-type indices)
//   - ITEM_*: bit-field indices into the packed own-item count vector
//   - SLOT_*: 2-bit magazine slot codes produced by the game-state encoder
//   - ST_*: decision FSM state encoding
//   - sat_sub4: 4-bit unsigned subtract clamped at zero
package ai_pkg;

    localparam int N_SLOTS = 8;

    typedef enum logic [3:0] {
        ACT_MAGNIFIER  = 4'd0,
        ACT_BEER       = 4'd1,
        ACT_SAW        = 4'd2,
        ACT_CIGARETTE  = 4'd3,
        ACT_HANDCUFF   = 4'd4,
        ACT_PHONE      = 4'd5,
        ACT_INVERTER   = 4'd6,
        ACT_SHOOT_SELF = 4'd8,
        ACT_SHOOT_OPP  = 4'd9,
        ACT_END_ITEM   = 4'd15
    } act_e;

    localparam int ITEM_MAGNIFIER = 0;
    localparam int ITEM_BEER      = 1;
    localparam int ITEM_SAW       = 2;
    localparam int ITEM_CIGARETTE = 3;

    localparam logic [1:0] SLOT_PAD   = 2'b00;
    localparam logic [1:0] SLOT_UNK   = 2'b01;
    localparam logic [1:0] SLOT_LIVE  = 2'b10;
    localparam logic [1:0] SLOT_BLANK = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SCAN   = 3'd1;
    localparam state_t ST_DECIDE = 3'd2;
    localparam state_t ST_ISSUE  = 3'd3;
    localparam state_t ST_SETTLE = 3'd4;

    function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : 4'd0;
    endfunction

endpackage

// File: rtl/ai_slot_counter.sv
// ai_slot_counter: serial magazine scanner, one slot per enabled cycle, k = 0..7.
//   clk, rst_n    : clock, async active-low reset
//   i_clear       : restart the scan (k = 0, counts cleared); takes precedence over i_en
//   i_en          : process slot k this cycle
//   i_slot        : packed slot codes, slot k = i_slot[2k+1:2k]
//   i_cur_idx     : index of the next slot to fire
//   o_kn_live     : known live rounds at or after i_cur_idx
//   o_kn_blank    : known blank rounds at or after i_cur_idx
//   o_cur_code    : code of slot i_cur_idx
//   o_scan_done   : high during the cycle that processes the last slot
module ai_slot_counter
    import ai_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [15:0] i_slot,
    input  logic [2:0]  i_cur_idx,
    output logic [3:0]  o_kn_live,
    output logic [3:0]  o_kn_blank,
    output logic [1:0]  o_cur_code,
    output logic        o_scan_done
);

    logic [2:0] k;
    logic [1:0] code;

    assign code        = i_slot[2*k +: 2];
    assign o_scan_done = i_en && (k == 3'(N_SLOTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= 3'd0;
            o_kn_live  <= 4'd0;
            o_kn_blank <= 4'd0;
            o_cur_code <= SLOT_PAD;
        end else if (i_clear) begin
            k          <= 3'd0;
            o_kn_live  <= 4'd0;
            o_kn_blank <= 4'd0;
            o_cur_code <= SLOT_PAD;
        end else if (i_en) begin
            // Slots already fired (below cur_idx) are history, not ammunition.
            if (k >= i_cur_idx) begin
                if (code == SLOT_LIVE)  o_kn_live  <= o_kn_live + 4'd1;
                if (code == SLOT_BLANK) o_kn_blank <= o_kn_blank + 4'd1;
            end
            if (k == i_cur_idx) o_cur_code <= code;
            k <= k + 3'd1;
        end
    end

endmodule

// File: rtl/ai_decision_engine.sv
// ai_decision_engine: per-turn action selector for the AI player.
//   clk, rst_n       : clock, async active-low reset
//   i_start          : one-cycle "your turn" pulse
//   i_phase_item     : item phase active
//   i_phase_shoot    : shoot phase active
//   i_slot           : packed 2-bit slot codes (8 slots)
//   i_cur_idx        : next slot to fire
//   i_live_rem       : live rounds remaining (current included)
//   i_blank_rem      : blank rounds remaining (current included)
//   i_hp_self        : own HP
//   i_item_cnt       : packed 3-bit own item counts, 7 types
//   o_act_valid      : action offered to controller
//   o_act_code       : action code, stable while offered
//   i_act_ready      : controller accepts action
//   o_busy           : engine not idle
//   o_done           : one-cycle pulse when the turn sequence completes
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for i_start with exactly one phase flag
// ST_SCAN   | 8 cycles, slot counter walks the magazine
// ST_DECIDE | apply policy, register the action code
// ST_ISSUE  | o_act_valid high until the controller takes it
// ST_SETTLE | 2 cycles for controller state to update, then rescan
module ai_decision_engine
    import ai_pkg::*;
#(
    parameter int MAX_HP        = 4,
    parameter int MAX_ITEM_ACTS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_phase_item,
    input  logic        i_phase_shoot,
    input  logic [15:0] i_slot,
    input  logic [2:0]  i_cur_idx,
    input  logic [3:0]  i_live_rem,
    input  logic [3:0]  i_blank_rem,
    input  logic [2:0]  i_hp_self,
    input  logic [20:0] i_item_cnt,
    output logic        o_act_valid,
    output logic [3:0]  o_act_code,
    input  logic        i_act_ready,
    output logic        o_busy,
    output logic        o_done
);

    state_t     state, state_nxt;
    logic [2:0] act_cnt;
    logic       saw_used;
    logic       item_mode;
    logic       settle_cnt;

    logic [3:0] kn_live, kn_blank;
    logic [1:0] cur_code;
    logic       scan_done, scan_clear, scan_en;

    logic       abort, start_ok, handshake, more_items;
    logic [3:0] unk_live, unk_blank;
    logic [3:0] item_act, shoot_act, decision;
    logic [2:0] cnt_mag, cnt_beer, cnt_saw, cnt_cig;
    logic       unused_items;

    assign abort      = !i_phase_item && !i_phase_shoot;
    assign start_ok   = i_start && (i_phase_item ^ i_phase_shoot);
    assign handshake  = o_act_valid && i_act_ready;
    assign more_items = item_mode && (o_act_code != ACT_END_ITEM);

    assign cnt_mag      = i_item_cnt[3*ITEM_MAGNIFIER +: 3];
    assign cnt_beer     = i_item_cnt[3*ITEM_BEER      +: 3];
    assign cnt_saw      = i_item_cnt[3*ITEM_SAW       +: 3];
    assign cnt_cig      = i_item_cnt[3*ITEM_CIGARETTE +: 3];
    assign unused_items = ^i_item_cnt[20:12];

    assign o_act_valid = (state == ST_ISSUE);
    assign o_busy      = (state != ST_IDLE);

    // Every entry into SCAN (fresh turn or post-settle rescan) restarts the counter.
    assign scan_en    = (state == ST_SCAN);
    assign scan_clear = (state_nxt == ST_SCAN) && (state != ST_SCAN);

    ai_slot_counter u_slot_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (scan_clear),
        .i_en        (scan_en),
        .i_slot      (i_slot),
        .i_cur_idx   (i_cur_idx),
        .o_kn_live   (kn_live),
        .o_kn_blank  (kn_blank),
        .o_cur_code  (cur_code),
        .o_scan_done (scan_done)
    );

    assign unk_live  = sat_sub4(i_live_rem, kn_live);
    assign unk_blank = sat_sub4(i_blank_rem, kn_blank);

    always_comb begin
        item_act = ACT_END_ITEM;
        if (act_cnt == 3'(MAX_ITEM_ACTS - 1))
            item_act = ACT_END_ITEM;
        else if ((i_hp_self < 3'(MAX_HP)) && (cnt_cig != 3'd0))
            item_act = ACT_CIGARETTE;
        else if ((cur_code == SLOT_UNK) && (cnt_mag != 3'd0))
            item_act = ACT_MAGNIFIER;
        else if ((cur_code == SLOT_LIVE) && (cnt_saw != 3'd0) && !saw_used)
            item_act = ACT_SAW;
        else if ((cur_code == SLOT_BLANK) && (cnt_beer != 3'd0))
            item_act = ACT_BEER;
    end

    always_comb begin
        shoot_act = ACT_SHOOT_SELF;
        case (cur_code)
            SLOT_LIVE:  shoot_act = ACT_SHOOT_OPP;
            SLOT_BLANK: shoot_act = ACT_SHOOT_SELF;
            SLOT_UNK:   shoot_act = (unk_live >= unk_blank) ? ACT_SHOOT_OPP : ACT_SHOOT_SELF;
            SLOT_PAD:   shoot_act = ACT_SHOOT_SELF;
        endcase
    end

    assign decision = item_mode ? item_act : shoot_act;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_ok) state_nxt = ST_SCAN;
            ST_SCAN:   if (abort) state_nxt = ST_IDLE;
                       else if (scan_done) state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = abort ? ST_IDLE : ST_ISSUE;
            ST_ISSUE:  if (abort) state_nxt = ST_IDLE;
                       else if (handshake) state_nxt = more_items ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: if (abort) state_nxt = ST_IDLE;
                       else if (settle_cnt == 1'b0) state_nxt = ST_SCAN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            act_cnt    <= 3'd0;
            saw_used   <= 1'b0;
            item_mode  <= 1'b0;
            settle_cnt <= 1'b0;
            o_act_code <= 4'hF;
            o_done     <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        item_mode <= i_phase_item;
                        act_cnt   <= 3'd0;
                        saw_used  <= 1'b0;
                    end
                end
                ST_DECIDE: begin
                    if (!abort) begin
                        o_act_code <= decision;
                        if (item_mode && (decision == ACT_SAW)) saw_used <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!abort && handshake) begin
                        act_cnt    <= act_cnt + 3'd1;
                        settle_cnt <= 1'b1;
                        if (!more_items) o_done <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != 1'b0) settle_cnt <= settle_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
